spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Parametrised SPI-loaded register bank with frame-synchronous commit, the successor to the fixed reg/vec SPI receivers driven from LA pins. An external SPI master writes address+data frames into a staging array; staged values move to the live outputs only on a commit pulse, normally end-of-frame/vsync, so rendering never sees a half-updated register set. It sits between the LA/GPIO SPI inputs and the renderer core inside the project top.

## Interface
- NUM_REGS, 8, number of registers (2..16)
- ADDR_W, 4, address field bits per frame; must satisfy 2^ADDR_W >= NUM_REGS
- DATA_W, 16, data bits per register and per frame (1..32)
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_sclk  in  1  SPI clock, asynchronous to i_clk, mode 0 (sample on rising edge)
- i_csb  in  1  SPI chip select, active-low, asynchronous
- i_mosi  in  1  SPI data, MSB first, asynchronous
- i_commit  in  1  commit request, synchronous, sampled every cycle
- i_immediate  in  1  1 = completed writes go straight to live outputs, synchronous
- o_regs  out  NUM_REGS*DATA_W  live values; register r at bits [r*DATA_W +: DATA_W]
- o_pending  out  1  at least one staged write not yet committed
- o_wr_strobe  out  1  one-cycle pulse per accepted complete frame
- o_abort  out  1  one-cycle pulse when a frame is cut short by csb

## Operation
- Inputs i_sclk/i_csb/i_mosi each pass through a 2-flop synchroniser; sclk rising edge and csb rising/falling edges detected from synchronised history.
- Frame = ADDR_W address bits then DATA_W data bits, MSB first, one bit per sclk rising edge while csb low.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: csb falling edge -> ADDR, bit counter cleared.
- ADDR: shift mosi into address; after ADDR_W bits -> DATA.
- DATA: shift into data shifter; after DATA_W bits: if address < NUM_REGS, write staging[addr], set pending[addr], pulse o_wr_strobe; else discard silently (no strobe). Either way -> DONE.
- DONE: further sclk edges ignored; csb rising edge -> IDLE.
- csb rising edge in ADDR or DATA -> IDLE, shifters discarded, o_abort pulse, staging untouched.
- csb low at any state other than IDLE is never a new frame; a new frame needs csb high then low.
- Commit: i_commit=1 -> for every r with pending[r]: live[r] <= staging[r], pending[r] <= 0.
- i_immediate=1 at write time: live[addr] and staging[addr] both written, pending[addr] not set.
- o_pending = OR of pending bits.

## Timing
- Reset: o_regs all 0, staging all 0, pending 0, o_pending 0, o_wr_strobe 0, o_abort 0, FSM IDLE, synchronisers cleared (csb sync reset to 1).
- Reset deassertion mid-frame: FSM restarts in IDLE; rest of that frame ignored until csb high then low.
- Input latency: pin change visible to FSM 2 cycles later; edge acted on in 3rd cycle.
- SPI requirement: sclk high and low each >= 3 i_clk periods; csb setup/hold to sclk >= 3 i_clk periods.
- o_wr_strobe / staging write occur the cycle the last data-bit edge is acted on; immediate mode live update same cycle (o_regs changes 1 cycle after).
- Commit: o_regs and o_pending change the cycle after i_commit sampled high.
- Same-cycle commit and write to register r: commit uses staging value prior to the write; new value lands in staging and pending[r] stays 1 for next commit.
- Same-cycle commit and write to another register: commit proceeds; the new register remains pending.
- i_commit held high multiple cycles: each cycle commits whatever is pending (effectively transparent).

## Structure
- Package rbz_spi_pkg: FSM state typedef (IDLE, ADDR, DATA, DONE), synchroniser depth constant (2).
- Sub-module spi_in_sync: per-bit 2-flop synchroniser plus previous-value flop giving rise/fall pulses; instantiated for sclk, csb, mosi (mosi uses level only).
- Bit counter width $clog2(ADDR_W+DATA_W+1); staging and live as NUM_REGS x DATA_W arrays.

## Test plan
- Defaults; frame addr 3, data 0xBEEF, i_immediate=0 -> o_wr_strobe once, o_pending=1, o_regs[3] still 0; pulse i_commit -> next cycle o_regs[3]=0xBEEF, o_pending=0.
- i_immediate=1, addr 0 data 0x1234 -> o_regs[0]=0x1234 one cycle after strobe, o_pending stays 0.
- Address 12 (>= NUM_REGS) data 0xFFFF -> no strobe, no abort, staging/o_regs unchanged.
- csb raised after 10 of 20 bits -> o_abort one pulse, no strobe, then a full frame addr 1 data 0x00A5 succeeds normally.
- Write addr 5 =0x1111, commit; write addr 5 =0x2222 with final bit coinciding with i_commit -> o_regs[5]=0x1111, o_pending=1; next commit -> 0x2222.
- i_reset_n low for 1 cycle mid-DATA -> all outputs 0; remaining sclk edges ignored until csb high then low; 24 extra sclks after a full frame ignored in DONE.

Source files
------------

// File: rtl/rbz_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rbz_spi_pkg
// Purpose  : Shared types and constants for the SPI-loaded register bank.
//            - spi_state_e : frame receiver states
//            - c_sync_depth: flops in each pin synchroniser chain
// Revision : 1.0 - initial release
// ============================================================================
package rbz_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam int c_sync_depth = 2;

endpackage : rbz_spi_pkg
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_in_sync
// Purpose  : Brings one asynchronous pin into the i_clk domain through a
//            c_sync_depth flop chain and derives single-cycle rise/fall
//            pulses from the synchronised history.
// Ports    : i_clk      - system clock
//            i_reset_n  - asynchronous active-low reset
//            i_pin      - asynchronous input pin
//            o_level    - synchronised level
//            o_rise     - one-cycle pulse on a synchronised 0->1 transition
//            o_fall     - one-cycle pulse on a synchronised 1->0 transition
// Revision : 1.0 - initial release
// ============================================================================
module spi_in_sync
    import rbz_spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [c_sync_depth-1:0] sync_q, sync_d;
    logic                    prev_q, prev_d;
    // Fills with ones after reset; edges are only reported once the chain
    // and the previous-value flop hold real pin samples rather than reset
    // values, so a pin already sitting at the "other" level when reset lifts
    // never produces a phantom edge.
    logic [c_sync_depth:0]   valid_q, valid_d;

    always_comb begin
        sync_d  = {sync_q[c_sync_depth-2:0], i_pin};
        prev_d  = sync_q[c_sync_depth-1];
        valid_d = {valid_q[c_sync_depth-1:0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= {c_sync_depth{RESET_VAL}};
            prev_q  <= RESET_VAL;
            valid_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
        end
    end

    assign o_level = sync_q[c_sync_depth-1];
    assign o_rise  = valid_q[c_sync_depth] &  o_level & ~prev_q;
    assign o_fall  = valid_q[c_sync_depth] & ~o_level &  prev_q;

endmodule : spi_in_sync
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : SPI-loaded register bank with frame-synchronous commit. Frames
//            of ADDR_W address bits then DATA_W data bits (MSB first) land in
//            a staging array; i_commit copies pending staged values to the
//            live outputs so the consumer never sees a half-updated set.
// Ports    : i_clk, i_reset_n        - clock, async active-low reset
//            i_sclk, i_csb, i_mosi   - asynchronous SPI mode-0 pins
//            i_commit                - move all pending staging -> live
//            i_immediate             - completed writes go straight to live
//            o_regs                  - live values, reg r at [r*DATA_W +: DATA_W]
//            o_pending               - some staged write not yet committed
//            o_wr_strobe             - pulse per accepted complete frame
//            o_abort                 - pulse when csb cuts a frame short
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import rbz_spi_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_sclk,
    input  logic                         i_csb,
    input  logic                         i_mosi,
    input  logic                         i_commit,
    input  logic                         i_immediate,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic                         o_pending,
    output logic                         o_wr_strobe,
    output logic                         o_abort
);

    localparam int                  c_frame_bits = ADDR_W + DATA_W;
    localparam int                  c_cnt_w      = $clog2(c_frame_bits + 1);
    localparam logic [c_cnt_w-1:0]  c_last_addr  = c_cnt_w'(ADDR_W - 1);
    localparam logic [c_cnt_w-1:0]  c_last_data  = c_cnt_w'(c_frame_bits - 1);
    localparam logic [ADDR_W:0]     c_num_regs   = (ADDR_W + 1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic sclk_level_unused, sclk_rise, sclk_fall_unused;
    logic csb_level_unused, csb_rise, csb_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_in_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_sclk),
        .o_level   (sclk_level_unused),
        .o_rise    (sclk_rise),
        .o_fall    (sclk_fall_unused)
    );

    spi_in_sync #(.RESET_VAL(1'b1)) u_sync_csb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_csb),
        .o_level   (csb_level_unused),
        .o_rise    (csb_rise),
        .o_fall    (csb_fall)
    );

    spi_in_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_mosi),
        .o_level   (mosi_level),
        .o_rise    (mosi_rise_unused),
        .o_fall    (mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    spi_state_e           state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic                 abort_q, abort_d;

    logic [ADDR_W-1:0]    addr_shift;
    logic [DATA_W-1:0]    data_shift;
    logic                 addr_ok;
    logic                 wr_en;

    assign addr_shift = (addr_q << 1) | ADDR_W'(mosi_level);
    assign data_shift = (data_q << 1) | DATA_W'(mosi_level);
    assign addr_ok    = ({1'b0, addr_q} < c_num_regs);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        abort_d  = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only a true high->low transition opens a frame.
                if (csb_fall) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                end
            end
            ST_ADDR: begin
                if (csb_rise) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    addr_d = addr_shift;
                    cnt_d  = cnt_q + c_cnt_w'(1);
                    if (cnt_q == c_last_addr) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (csb_rise) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    data_d = data_shift;
                    cnt_d  = cnt_q + c_cnt_w'(1);
                    if (cnt_q == c_last_data) begin
                        // Out-of-range addresses are dropped without a strobe.
                        state_d  = ST_DONE;
                        wr_en    = addr_ok;
                        strobe_d = addr_ok;
                    end
                end
            end
            ST_DONE: begin
                if (csb_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Staging / live arrays
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   staging_q [NUM_REGS];
    logic [DATA_W-1:0]   staging_d [NUM_REGS];
    logic [DATA_W-1:0]   live_q    [NUM_REGS];
    logic [DATA_W-1:0]   live_d    [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;

    always_comb begin
        staging_d = staging_q;
        live_d    = live_q;
        pending_d = pending_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            // Commit is evaluated first from the pre-write staging value, so a
            // write landing in the same cycle stays pending for the next one.
            if (i_commit && pending_q[r]) begin
                live_d[r]    = staging_q[r];
                pending_d[r] = 1'b0;
            end
            if (wr_en && (addr_q == ADDR_W'(r))) begin
                staging_d[r] = data_shift;
                if (i_immediate) begin
                    live_d[r]    = data_shift;
                    pending_d[r] = 1'b0;
                end else begin
                    pending_d[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            abort_q   <= 1'b0;
            staging_q <= '{default: '0};
            live_q    <= '{default: '0};
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            abort_q   <= abort_d;
            staging_q <= staging_d;
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
            assign o_regs[r*DATA_W +: DATA_W] = live_q[r];
        end
    endgenerate

    assign o_pending   = |pending_q;
    assign o_wr_strobe = strobe_q;
    assign o_abort     = abort_q;

endmodule : spi_reg_bank
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bank
// Purpose  : Self-checking bench for spi_reg_bank. Drives SPI frames on the
//            asynchronous pins, keeps a staging/live/pending array model and
//            compares outputs after directed and randomised sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int FB       = ADDR_W + DATA_W;
    localparam int VW       = NUM_REGS * DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          csb = 1'b1;
    logic          mosi = 1'b0;
    logic          commit = 1'b0;
    logic          imm = 1'b0;
    logic [VW-1:0] o_regs;
    logic          o_pending, o_wr_strobe, o_abort;

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_sclk      (sclk),
        .i_csb       (csb),
        .i_mosi      (mosi),
        .i_commit    (commit),
        .i_immediate (imm),
        .o_regs      (o_regs),
        .o_pending   (o_pending),
        .o_wr_strobe (o_wr_strobe),
        .o_abort     (o_abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int n_strobe = 0, n_abort = 0, exp_strobe = 0, exp_abort = 0;

    // Pulse counters: a pulse lasting more than one cycle counts twice.
    always @(negedge clk) begin
        if (o_wr_strobe) n_strobe++;
        if (o_abort)     n_abort++;
    end

    // Behavioural model of the bank.
    logic [DATA_W-1:0] m_stage [NUM_REGS];
    logic [DATA_W-1:0] m_live  [NUM_REGS];
    bit                m_pend  [NUM_REGS];

    task automatic m_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_stage[r] = '0; m_live[r] = '0; m_pend[r] = 1'b0;
        end
    endtask

    task automatic m_commit();
        for (int r = 0; r < NUM_REGS; r++)
            if (m_pend[r]) begin m_live[r] = m_stage[r]; m_pend[r] = 1'b0; end
    endtask

    task automatic m_write(input int a, input logic [DATA_W-1:0] d, input bit im);
        if (a < NUM_REGS) begin
            m_stage[a] = d;
            if (im) begin m_live[a] = d; m_pend[a] = 1'b0; end
            else m_pend[a] = 1'b1;
            exp_strobe++;
        end
    endtask

    function automatic logic [VW-1:0] exp_regs();
        logic [VW-1:0] v;
        for (int r = 0; r < NUM_REGS; r++) v[r*DATA_W +: DATA_W] = m_live[r];
        return v;
    endfunction

    function automatic bit exp_pend();
        bit p = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) p |= m_pend[r];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk); #1;
        chk({tag, " regs"},    o_regs, exp_regs());
        chk({tag, " pending"}, VW'(o_pending), VW'(exp_pend()));
        chk({tag, " strobes"}, VW'(n_strobe), VW'(exp_strobe));
        chk({tag, " aborts"},  VW'(n_abort), VW'(exp_abort));
    endtask

    // One SPI bit; optionally raise i_commit for exactly the cycle in which
    // the bank acts on this sclk rising edge (three cycles after it is driven).
    task automatic spi_bit(input logic b, input bit co);
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        if (co) begin
            repeat (2) @(negedge clk);
            commit = 1'b1;
            @(negedge clk);
            commit = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        sclk = 1'b0;
    endtask

    task automatic send_frame(input int a, input logic [DATA_W-1:0] d, input int nbits,
                              input bit im, input bit co, input int extra);
        logic [FB-1:0] fr;
        fr  = {ADDR_W'(a), d};
        imm = im;
        csb = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) spi_bit(fr[FB-1-i], co && (i == FB-1));
        for (int e = 0; e < extra; e++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (4) @(negedge clk);
        csb = 1'b1;
        repeat (6) @(negedge clk);
        imm = 1'b0;
        if (nbits == FB) begin
            if (co) m_commit();
            m_write(a, d, im);
        end else begin
            exp_abort++;
        end
    endtask

    task automatic do_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        m_commit();
        #1;
        chk("commit next-cycle regs", o_regs, exp_regs());
    endtask

    initial begin
        logic [FB-1:0] fr;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset regs", o_regs, '0);
        chk("reset pending", VW'(o_pending), '0);
        chk("reset strobe", VW'(o_wr_strobe), '0);
        chk("reset abort", VW'(o_abort), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Staged write, then commit
        send_frame(3, 16'hBEEF, FB, 1'b0, 1'b0, 0);
        check_all("staged addr3");
        chk("staged addr3 live slice", VW'(o_regs[3*DATA_W +: DATA_W]), '0);
        do_commit();
        check_all("commit addr3");

        // Immediate write
        send_frame(0, 16'h1234, FB, 1'b1, 1'b0, 0);
        check_all("immediate addr0");

        // Out-of-range address
        send_frame(12, 16'hFFFF, FB, 1'b0, 1'b0, 0);
        check_all("addr12 discard");

        // Aborted frame then good frame
        send_frame(1, 16'h00A5, 10, 1'b0, 1'b0, 0);
        check_all("abort after 10");
        send_frame(1, 16'h00A5, FB, 1'b0, 1'b0, 0);
        check_all("after abort addr1");
        do_commit();

        // Commit coinciding with the final data bit
        send_frame(5, 16'h1111, FB, 1'b0, 1'b0, 0);
        do_commit();
        send_frame(5, 16'h2222, FB, 1'b0, 1'b1, 0);
        check_all("coincident commit");
        chk("coincident addr5", VW'(o_regs[5*DATA_W +: DATA_W]), VW'(16'h1111));
        do_commit();
        chk("second commit addr5", VW'(o_regs[5*DATA_W +: DATA_W]), VW'(16'h2222));

        // Reset mid-DATA; remainder of the frame must be ignored
        fr  = {4'd2, 16'h5A5A};
        csb = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < ADDR_W + 5; i++) spi_bit(fr[FB-1-i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("midframe reset regs", o_regs, '0);
        chk("midframe reset pending", VW'(o_pending), '0);
        chk("midframe reset strobe", VW'(o_wr_strobe), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = ADDR_W + 5; i < FB; i++) spi_bit(fr[FB-1-i], 1'b0);
        check_all("post-reset tail ignored");
        repeat (4) @(negedge clk);
        csb = 1'b1;
        repeat (6) @(negedge clk);
        check_all("post-reset csb high");
        send_frame(2, 16'h5A5A, FB, 1'b0, 1'b0, 24);
        check_all("extra sclks in DONE");
        do_commit();
        check_all("commit addr2");

        // Randomised frames, aborts and commits against the model
        for (int it = 0; it < 40; it++) begin
            int op, a, nb;
            bit im, co;
            logic [DATA_W-1:0] d;
            op = int'($urandom_range(0, 9));
            a  = int'($urandom_range(0, 15));
            d  = DATA_W'($urandom);
            im = ($urandom_range(0, 3) == 0);
            if (a < NUM_REGS && m_pend[a]) im = 1'b0;
            if (op <= 1) begin
                do_commit();
            end else if (op == 2) begin
                nb = int'($urandom_range(0, FB - 1));
                send_frame(a, d, nb, 1'b0, 1'b0, 0);
            end else if (op == 9) begin
                send_frame(a, d, FB, 1'b0, 1'b1, 0);
            end else begin
                send_frame(a, d, FB, im, 1'b0, 0);
            end
            check_all($sformatf("random %0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_reg_bank
`default_nettype wire
